// File: rtl/usb_rx_core.sv
// rtl/usb_rx_core.sv - USB 1.x receive core: line sync, bit recovery, NRZI/unstuff, SYNC check, byte FIFO
module usb_rx_core #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int LOW_SPEED    = 0
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus,
    input  logic       d_minus,
    input  logic       r_enable,
    output logic [7:0] r_data,
    output logic       empty,
    output logic       full,
    output logic       rcving,
    output logic       r_error,
    output logic       pkt_done
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CW-1:0] SAMPLE_AT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_WAIT, ERR_WAIT} state_e;

    state_e          state_q, state_d;
    logic            dp_meta_q, dp_s_q, dm_meta_q, dm_s_q, dp_prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            lvl_q, lvl_d;
    logic [2:0]      ones_q, ones_d;
    logic [2:0]      bc_q, bc_d;
    logic [6:0]      sh_q, sh_d;
    logic            eop_seen_q, eop_seen_d;
    logic            rcving_q, rcving_d;
    logic            r_error_q, r_error_d;
    logic            pkt_done_q, pkt_done_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] fcnt_q, fcnt_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic dp_raw, dm_raw, d_edge, se0, sample, eop_smp, nrzi_bit;
    logic stuff_drop, stuff_err, bit_ok, byte_done, push, pop, go_err;
    logic [7:0] byte_val;

    // Low speed idles with D- high, so swapping the lines lets everything downstream treat J as dp=1.
    assign dp_raw = (LOW_SPEED != 0) ? d_minus : d_plus;
    assign dm_raw = (LOW_SPEED != 0) ? d_plus  : d_minus;

    assign d_edge     = dp_s_q != dp_prev_q;
    assign se0        = !dp_s_q && !dm_s_q;
    assign sample     = rcving_q && (cnt_q == SAMPLE_AT);
    assign eop_smp    = sample && se0;
    assign nrzi_bit   = (dp_s_q == lvl_q);
    assign stuff_drop = sample && !se0 && (ones_q == 3'd6) && !nrzi_bit;
    assign stuff_err  = sample && !se0 && (ones_q == 3'd6) && nrzi_bit;
    assign bit_ok     = sample && !se0 && (ones_q != 3'd6);
    assign byte_done  = bit_ok && (bc_q == 3'd7);
    assign byte_val   = {nrzi_bit, sh_q};

    assign empty    = (fcnt_q == '0);
    assign full     = (fcnt_q == CNTW'(FIFO_DEPTH));
    assign pop      = r_enable && !empty;
    assign r_data   = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign rcving   = rcving_q;
    assign r_error  = r_error_q;
    assign pkt_done = pkt_done_q;

    always_comb begin
        if (d_edge || !rcving_q || cnt_q == LAST_CNT) cnt_d = '0;
        else                                          cnt_d = cnt_q + 1'b1;

        lvl_d      = (sample && !se0) ? dp_s_q : lvl_q;
        ones_d     = ones_q;
        bc_d       = bc_q;
        sh_d       = sh_q;
        if (stuff_drop) begin
            ones_d = '0;
        end else if (bit_ok) begin
            ones_d = nrzi_bit ? ones_q + 3'd1 : 3'd0;
            bc_d   = bc_q + 3'd1;
            sh_d   = byte_val[7:1];
        end

        state_d    = state_q;
        rcving_d   = rcving_q;
        r_error_d  = r_error_q;
        pkt_done_d = 1'b0;
        eop_seen_d = eop_seen_q;
        push       = 1'b0;
        go_err     = 1'b0;

        case (state_q)
            IDLE: begin
                lvl_d      = 1'b1;
                ones_d     = '0;
                bc_d       = '0;
                eop_seen_d = 1'b0;
                if (d_edge) begin
                    state_d   = SYNC;
                    rcving_d  = 1'b1;
                    r_error_d = 1'b0;
                end
            end
            SYNC: begin
                if (stuff_err || eop_smp) go_err = 1'b1;
                else if (byte_done) begin
                    if (byte_val == 8'h80) state_d = DATA;
                    else                   go_err  = 1'b1;
                end
            end
            DATA: begin
                if (stuff_err) go_err = 1'b1;
                else if (eop_smp) begin
                    if (bc_q == 3'd0) state_d = EOP_WAIT;
                    else              go_err  = 1'b1;
                end else if (byte_done) begin
                    if (full && !r_enable) go_err = 1'b1;
                    else                   push   = 1'b1;
                end
            end
            EOP_WAIT: begin
                if (dp_s_q) begin
                    state_d    = IDLE;
                    rcving_d   = 1'b0;
                    pkt_done_d = 1'b1;
                end
            end
            ERR_WAIT: begin
                if (eop_smp) eop_seen_d = 1'b1;
                if (eop_seen_q && dp_s_q && !dm_s_q) begin
                    state_d  = IDLE;
                    rcving_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A truncated byte is detected on the EOP sample itself, so that sample already counts as seen.
        if (go_err) begin
            state_d    = ERR_WAIT;
            r_error_d  = 1'b1;
            eop_seen_d = eop_smp;
        end

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        fcnt_d   = fcnt_q + CNTW'(push) - CNTW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            dp_meta_q  <= 1'b1;
            dp_s_q     <= 1'b1;
            dm_meta_q  <= 1'b0;
            dm_s_q     <= 1'b0;
            dp_prev_q  <= 1'b1;
            cnt_q      <= '0;
            lvl_q      <= 1'b1;
            ones_q     <= '0;
            bc_q       <= '0;
            sh_q       <= '0;
            eop_seen_q <= 1'b0;
            rcving_q   <= 1'b0;
            r_error_q  <= 1'b0;
            pkt_done_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            dp_meta_q  <= dp_raw;
            dp_s_q     <= dp_meta_q;
            dm_meta_q  <= dm_raw;
            dm_s_q     <= dm_meta_q;
            dp_prev_q  <= dp_s_q;
            cnt_q      <= cnt_d;
            lvl_q      <= lvl_d;
            ones_q     <= ones_d;
            bc_q       <= bc_d;
            sh_q       <= sh_d;
            eop_seen_q <= eop_seen_d;
            rcving_q   <= rcving_d;
            r_error_q  <= r_error_d;
            pkt_done_q <= pkt_done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= byte_val;
    end

endmodule
